// File: rtl/instr_mem_loader.sv
// Instruction-memory loader: packs UART bytes big-endian into 32-bit words
// and writes them from address 0 until HALT or the memory is full.
//
// Ports:
//   i_clk, i_reset (async, active-low)
//   i_start        : begin or restart a load; wins over a coincident byte
//   i_rx_done      : byte strobe; i_rx_data carries the byte
//   o_wr_en        : one-cycle write strobe, with o_wr_addr / o_wr_data
//   o_loading      : high in RECV or WRITE
//   o_done         : HALT written
//   o_full         : last address written without HALT
//   o_instr_count  : words written in this load, HALT included
module instr_mem_loader #(
    parameter int                            INSTRUCTION_SIZE = 32,
    parameter int                            BYTE_SIZE        = 8,
    parameter int                            MEM_ADDR_BITS    = 8,
    parameter logic [INSTRUCTION_SIZE-1:0]   HALT_INSTR       = 32'hFFFFFFFF
) (
    input  logic                          i_clk,
    input  logic                          i_reset,
    input  logic                          i_start,
    input  logic                          i_rx_done,
    input  logic [BYTE_SIZE-1:0]          i_rx_data,
    output logic                          o_wr_en,
    output logic [MEM_ADDR_BITS-1:0]      o_wr_addr,
    output logic [INSTRUCTION_SIZE-1:0]   o_wr_data,
    output logic                          o_loading,
    output logic                          o_done,
    output logic                          o_full,
    output logic [MEM_ADDR_BITS:0]        o_instr_count
);

    // Only the three most recent bytes need to be kept; the fourth
    // completes the word directly from i_rx_data.
    localparam int LOW_W = INSTRUCTION_SIZE - BYTE_SIZE;

    localparam logic [MEM_ADDR_BITS-1:0] LAST_ADDR = '1;
    localparam logic [MEM_ADDR_BITS-1:0] ADDR_ONE  = MEM_ADDR_BITS'(1);
    localparam logic [MEM_ADDR_BITS:0]   CNT_ONE   = (MEM_ADDR_BITS+1)'(1);

    typedef enum logic [2:0] {
        IDLE,
        RECV,
        WRITE,
        DONE,
        FULL
    } state_t;

    state_t                        state_q;
    logic [1:0]                    bcnt_q;
    logic [LOW_W-1:0]              shift_q;
    logic [INSTRUCTION_SIZE-1:0]   wr_data_q;
    logic [MEM_ADDR_BITS-1:0]      addr_q;
    logic [MEM_ADDR_BITS:0]        count_q;
    logic                          wr_en_q;
    logic                          done_q;
    logic                          full_q;
    logic [INSTRUCTION_SIZE-1:0]   word_d;

    // First byte of a word ends up in the top byte (big-endian).
    assign word_d = {shift_q, i_rx_data};

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q   <= IDLE;
            bcnt_q    <= '0;
            shift_q   <= '0;
            wr_data_q <= '0;
            addr_q    <= '0;
            count_q   <= '0;
            wr_en_q   <= 1'b0;
            done_q    <= 1'b0;
            full_q    <= 1'b0;
        end else begin
            wr_en_q <= 1'b0;
            if (i_start) begin
                state_q <= RECV;
                bcnt_q  <= '0;
                shift_q <= '0;
                addr_q  <= '0;
                count_q <= '0;
                done_q  <= 1'b0;
                full_q  <= 1'b0;
            end else begin
                unique case (state_q)
                    RECV: begin
                        if (i_rx_done) begin
                            shift_q <= word_d[LOW_W-1:0];
                            if (bcnt_q == 2'd3) begin
                                bcnt_q    <= '0;
                                wr_data_q <= word_d;
                                wr_en_q   <= 1'b1;
                                state_q   <= WRITE;
                            end else begin
                                bcnt_q <= bcnt_q + 2'd1;
                            end
                        end
                    end
                    WRITE: begin
                        count_q <= count_q + CNT_ONE;
                        if (wr_data_q == HALT_INSTR) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else if (addr_q == LAST_ADDR) begin
                            state_q <= FULL;
                            full_q  <= 1'b1;
                        end else begin
                            addr_q  <= addr_q + ADDR_ONE;
                            state_q <= RECV;
                            // A byte arriving now is byte 0 of the next word.
                            if (i_rx_done) begin
                                shift_q <= word_d[LOW_W-1:0];
                                bcnt_q  <= 2'd1;
                            end
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign o_wr_en       = wr_en_q;
    assign o_wr_addr     = addr_q;
    assign o_wr_data     = wr_data_q;
    assign o_done        = done_q;
    assign o_full        = full_q;
    assign o_instr_count = count_q;
    assign o_loading     = (state_q == RECV) || (state_q == WRITE);

endmodule
